// File: rtl/tlk2711_rx_framer.sv
// rtl/tlk2711_rx_framer.sv - TLK2711 16-bit receive word lock and frame delineation
//
// Purpose:
//   Locks onto repeated SP sync words, then cuts the received word stream
//   into frames bounded by SF and EF. Payload words leave through a one-word
//   hold register so the final word of a frame can be flagged with o_last.
//   Fixed latency: a payload word at i_rxd in cycle t appears at o_data in t+3.
//
// Optional feature:
//   TLK2711_RX_STATS_EN - adds saturating good-frame, abort and lock-loss
//   counters (o_frame_cnt, o_err_cnt, o_los_cnt).
//
// Ports:
//   clk          RX recovered clock, single domain
//   rst          synchronous active-high reset
//   i_rkmsb      K flag for i_rxd[15:8]
//   i_rklsb      K flag for i_rxd[7:0]
//   i_rxd        received word, one per clock
//   o_locked     1 while not hunting for sync
//   o_data       payload word (holds when o_valid=0)
//   o_valid      o_data qualifier
//   o_last       final word of a frame (normal end or abort)
//   o_err        frame aborted (with o_last, or alone for an empty frame)
//   o_len        payload word count, meaningful with o_last
//   o_frame_cnt  good frames          (stats build only)
//   o_err_cnt    aborted frames       (stats build only)
//   o_los_cnt    lock-loss events     (stats build only)
module tlk2711_rx_framer #(
  parameter int SYNC_NUM  = 4,
  parameter int MAX_WORDS = 1024,
  parameter int LEN_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rkmsb,
  input  logic             i_rklsb,
  input  logic [15:0]      i_rxd,
  output logic             o_locked,
  output logic [15:0]      o_data,
  output logic             o_valid,
  output logic             o_last,
  output logic             o_err,
  output logic [LEN_W-1:0] o_len
`ifdef TLK2711_RX_STATS_EN
  ,
  output logic [31:0]      o_frame_cnt,
  output logic [31:0]      o_err_cnt,
  output logic [15:0]      o_los_cnt
`endif
);

  localparam int                SYNC_W    = $clog2(SYNC_NUM + 1);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_NUM - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_WORDS);

  typedef enum logic [1:0] {HUNT, LOCK, DATA} state_t;

  state_t            state, state_n;
  logic [15:0]       rx_r;
  logic [1:0]        k_r;
  logic [SYNC_W-1:0] sync_cnt, sync_n;
  logic [LEN_W-1:0]  len, len_n;
  logic [15:0]       hold_data, hold_n;
  logic              hold_vld, hold_vld_n;
  logic              valid_n, last_n, err_n;
  logic [15:0]       data_n;
  logic [LEN_W-1:0]  len_out_n;

  logic is_sp, is_sf, is_ef, is_dat, accept;

  assign is_sp  = (k_r == 2'b01) && (rx_r == 16'hC5BC);
  assign is_sf  = (k_r == 2'b11) && (rx_r == 16'h5CFB);
  assign is_ef  = (k_r == 2'b11) && (rx_r == 16'hFDFE);
  assign is_dat = (k_r == 2'b00);
  // A data word is only taken while the frame still has room.
  assign accept = is_dat && (len != LEN_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_r <= '0;
      k_r  <= '0;
    end else begin
      rx_r <= i_rxd;
      k_r  <= {i_rkmsb, i_rklsb};
    end
  end

  always_comb begin
    state_n    = state;
    sync_n     = sync_cnt;
    len_n      = len;
    hold_n     = hold_data;
    hold_vld_n = hold_vld;
    valid_n    = 1'b0;
    last_n     = 1'b0;
    err_n      = 1'b0;
    data_n     = o_data;
    len_out_n  = o_len;
    case (state)
      HUNT: begin
        if (is_sp) begin
          if (sync_cnt == SYNC_LAST) begin
            state_n = LOCK;
            sync_n  = '0;
          end else begin
            sync_n = sync_cnt + SYNC_W'(1);
          end
        end else begin
          sync_n = '0;
        end
      end
      LOCK: begin
        if (is_sf) begin
          state_n    = DATA;
          len_n      = '0;
          hold_vld_n = 1'b0;
        end else if (!is_sp) begin
          state_n = HUNT;
        end
      end
      DATA: begin
        // Every decision in DATA releases the held word, if there is one.
        valid_n = hold_vld;
        if (hold_vld) begin
          data_n    = hold_data;
          len_out_n = len;
        end
        if (accept) begin
          hold_n     = rx_r;
          hold_vld_n = 1'b1;
          len_n      = len + LEN_W'(1);
        end else begin
          // EF ends cleanly; anything else (incl. overflow DAT) aborts.
          // With an empty hold an abort still raises a lone err pulse.
          last_n     = hold_vld;
          err_n      = !is_ef;
          hold_vld_n = 1'b0;
          state_n    = is_ef ? LOCK : HUNT;
        end
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      sync_cnt  <= '0;
      len       <= '0;
      hold_data <= '0;
      hold_vld  <= 1'b0;
      o_locked  <= 1'b0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      o_err     <= 1'b0;
      o_len     <= '0;
    end else begin
      state     <= state_n;
      sync_cnt  <= sync_n;
      len       <= len_n;
      hold_data <= hold_n;
      hold_vld  <= hold_vld_n;
      o_locked  <= (state_n != HUNT);
      o_data    <= data_n;
      o_valid   <= valid_n;
      o_last    <= last_n;
      o_err     <= err_n;
      o_len     <= len_out_n;
    end
  end

`ifdef TLK2711_RX_STATS_EN
  logic frame_inc, abort_inc, los_inc;

  // Empty frames (SF then EF) are not counted as good frames.
  assign frame_inc = (state == DATA) && !accept && is_ef && hold_vld;
  assign abort_inc = (state == DATA) && !accept && !is_ef;
  assign los_inc   = (state != HUNT) && (state_n == HUNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_frame_cnt <= '0;
      o_err_cnt   <= '0;
      o_los_cnt   <= '0;
    end else begin
      if (frame_inc && !(&o_frame_cnt)) o_frame_cnt <= o_frame_cnt + 32'd1;
      if (abort_inc && !(&o_err_cnt))   o_err_cnt   <= o_err_cnt + 32'd1;
      if (los_inc && !(&o_los_cnt))     o_los_cnt   <= o_los_cnt + 16'd1;
    end
  end
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_tlk2711_rx_framer.sv
// tb/tb_tlk2711_rx_framer.sv - self-checking bench for tlk2711_rx_framer
module tb_tlk2711_rx_framer;

  localparam int SYNC_NUM  = 4;
  localparam int MAX_WORDS = 1024;
  localparam int LEN_W     = $clog2(MAX_WORDS + 1);

  localparam logic [15:0] SP = 16'hC5BC;
  localparam logic [15:0] SF = 16'h5CFB;
  localparam logic [15:0] EF = 16'hFDFE;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rkmsb = 1'b0;
  logic             rklsb = 1'b0;
  logic [15:0]      rxd = '0;
  logic             locked;
  logic [15:0]      data;
  logic             valid;
  logic             last;
  logic             err;
  logic [LEN_W-1:0] len;
`ifdef TLK2711_RX_STATS_EN
  logic [31:0]      frame_cnt;
  logic [31:0]      err_cnt;
  logic [15:0]      los_cnt;
`endif

  tlk2711_rx_framer #(.SYNC_NUM(SYNC_NUM), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst), .i_rkmsb(rkmsb), .i_rklsb(rklsb), .i_rxd(rxd),
    .o_locked(locked), .o_data(data), .o_valid(valid), .o_last(last),
    .o_err(err), .o_len(len)
`ifdef TLK2711_RX_STATS_EN
    , .o_frame_cnt(frame_cnt), .o_err_cnt(err_cnt), .o_los_cnt(los_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        locked, valid, last, err, chk_len;
    logic [15:0] data;
    int          len, fc, ec, lc;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: lock flag, frame flag, payload queue of the current frame.
  bit          m_locked, m_in_frame;
  int          m_run, m_fc, m_ec, m_lc;
  logic [15:0] m_q[$];
  logic [15:0] m_last_data;
  exp_t        e_old1, e_old2;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.locked = 0; e.valid = 0; e.last = 0; e.err = 0; e.chk_len = 0;
    e.data = '0; e.len = 0; e.fc = 0; e.ec = 0; e.lc = 0;
    return e;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_in_frame = 0; m_run = 0;
    m_fc = 0; m_ec = 0; m_lc = 0;
    m_q.delete();
    m_last_data = '0;
    e_old1 = zero_exp();
    e_old2 = zero_exp();
  endtask

  task automatic model_word(input logic [15:0] w, input logic [1:0] k, output exp_t e);
    bit sp, sf, ef, dat;
    sp  = (k == 2'b01) && (w == SP);
    sf  = (k == 2'b11) && (w == SF);
    ef  = (k == 2'b11) && (w == EF);
    dat = (k == 2'b00);
    e = zero_exp();
    if (!m_locked) begin
      if (sp) begin
        m_run++;
        if (m_run == SYNC_NUM) begin m_locked = 1; m_run = 0; end
      end else m_run = 0;
    end else if (!m_in_frame) begin
      if (sf) begin m_in_frame = 1; m_q.delete(); end
      else if (!sp) begin m_locked = 0; m_lc++; end
    end else if (dat && m_q.size() < MAX_WORDS) begin
      if (m_q.size() > 0) begin e.valid = 1; m_last_data = m_q[$]; end
      m_q.push_back(w);
    end else begin
      if (m_q.size() > 0) begin
        e.valid = 1; e.last = 1; e.chk_len = 1; e.len = m_q.size();
        m_last_data = m_q[$];
        if (ef) m_fc++;
      end
      if (!ef) begin e.err = 1; m_ec++; m_locked = 0; m_lc++; end
      m_in_frame = 0;
    end
    e.locked = m_locked;
    e.data   = m_last_data;
    e.fc = m_fc; e.ec = m_ec; e.lc = m_lc;
  endtask

  task automatic check(input exp_t e);
    cmp("locked", {31'd0, locked}, {31'd0, e.locked});
    cmp("valid",  {31'd0, valid},  {31'd0, e.valid});
    cmp("last",   {31'd0, last},   {31'd0, e.last});
    cmp("err",    {31'd0, err},    {31'd0, e.err});
    cmp("data",   {16'd0, data},   {16'd0, e.data});
    if (e.chk_len) cmp("len", 32'(len), 32'(e.len));
`ifdef TLK2711_RX_STATS_EN
    cmp("frame_cnt", frame_cnt, 32'(e.fc));
    cmp("err_cnt",   err_cnt,   32'(e.ec));
    cmp("los_cnt",   {16'd0, los_cnt}, 32'(e.lc));
`endif
  endtask

  // Outputs at a negedge reflect the word applied two negedges earlier.
  task automatic step(input logic [15:0] w, input logic [1:0] k);
    exp_t e;
    @(negedge clk);
    check(e_old2);
    model_word(w, k, e);
    e_old2 = e_old1;
    e_old1 = e;
    rxd = w;
    {rkmsb, rklsb} = k;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rxd = '0; {rkmsb, rklsb} = 2'b00;
    @(negedge clk);
    cmp("rst_locked", {31'd0, locked}, 32'd0);
    cmp("rst_valid",  {31'd0, valid},  32'd0);
    cmp("rst_last",   {31'd0, last},   32'd0);
    cmp("rst_err",    {31'd0, err},    32'd0);
    cmp("rst_data",   {16'd0, data},   32'd0);
    cmp("rst_len",    32'(len),        32'd0);
`ifdef TLK2711_RX_STATS_EN
    cmp("rst_frame_cnt", frame_cnt, 32'd0);
    cmp("rst_err_cnt",   err_cnt,   32'd0);
    cmp("rst_los_cnt",   {16'd0, los_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic sync_up();
    repeat (SYNC_NUM) step(SP, 2'b01);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    do_reset();

    // Basic three-word frame.
    sync_up();
    step(SF, 2'b11);
    step(16'h0001, 2'b00); step(16'h0002, 2'b00); step(16'h0003, 2'b00);
    step(EF, 2'b11);
    repeat (3) step(SP, 2'b01);

    // Broken sync run must restart the count.
    do_reset();
    repeat (3) step(SP, 2'b01);
    step(16'h0042, 2'b00);
    repeat (SYNC_NUM + 2) step(SP, 2'b01);

    // Overflow: word MAX_WORDS+1 aborts and is dropped.
    step(SF, 2'b11);
    for (int i = 1; i <= MAX_WORDS + 1; i++) step(16'(i + 16'h0100), 2'b00);
    repeat (SYNC_NUM + 2) step(SP, 2'b01);

    // Abort on a word with a stray K flag.
    step(SF, 2'b11);
    step(16'hAAAA, 2'b00); step(16'hBBBB, 2'b00);
    step(16'h1234, 2'b10);
    repeat (SYNC_NUM + 2) step(SP, 2'b01);

    // Empty frame, then empty-hold abort.
    do_reset();
    sync_up();
    step(SF, 2'b11); step(EF, 2'b11);
    step(SF, 2'b11); step(16'h00FF, 2'b10);
    repeat (3) step(SP, 2'b01);

    // Reset in the middle of a frame.
    sync_up();
    step(SF, 2'b11);
    step(16'h1111, 2'b00); step(16'h2222, 2'b00);
    do_reset();
    repeat (3) step(SP, 2'b01);

    // Randomized frames with random terminations and junk words.
    for (int f = 0; f < 150; f++) begin
      int n;
      n = $urandom_range(0, 4);
      repeat (n) step(SP, 2'b01);
      if ($urandom_range(0, 9) == 0) step(16'($urandom), 2'($urandom_range(0, 3)));
      if (!m_locked) sync_up();
      step(SF, 2'b11);
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++) step(16'($urandom), 2'b00);
      case ($urandom_range(0, 5))
        0:       step(16'($urandom), 2'($urandom_range(1, 3)));
        1:       step(SP, 2'b01);
        2:       step(SF, 2'b11);
        default: step(EF, 2'b11);
      endcase
    end
    repeat (4) step(SP, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
